// File: rtl/unswap_decoder.sv
`default_nettype none
// ============================================================================
// Module   : unswap_decoder
// Purpose  : Bit-serial inverse of the matrix encoder's 5x5 swap permutation,
//            applied ROUNDS times per 25-bit line over valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module unswap_decoder #(
    parameter int ROUNDS = 1,
    parameter int RW     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] in_line,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [24:0] out_line,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0]    c_last_bit = 5'd24;
    localparam logic [RW-1:0] c_last_rnd = RW'(ROUNDS - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [24:0]   r_src;
    logic [24:0]   r_dst;
    logic [24:0]   r_out_line;
    logic [24:0]   w_dst_upd;
    logic [4:0]    r_cnt;
    logic [4:0]    w_fwd;
    logic [RW-1:0] r_rnd;
    logic          w_last_bit;
    logic          w_last_rnd;

    // Source bit index feeding destination bit r_cnt in one decode pass.
    always_comb begin
        w_fwd = 5'd0;
        case (r_cnt)
            5'd0:  w_fwd = 5'd10;
            5'd1:  w_fwd = 5'd20;
            5'd2:  w_fwd = 5'd5;
            5'd3:  w_fwd = 5'd15;
            5'd4:  w_fwd = 5'd0;
            5'd5:  w_fwd = 5'd1;
            5'd6:  w_fwd = 5'd11;
            5'd7:  w_fwd = 5'd21;
            5'd8:  w_fwd = 5'd6;
            5'd9:  w_fwd = 5'd16;
            5'd10: w_fwd = 5'd17;
            5'd11: w_fwd = 5'd2;
            5'd12: w_fwd = 5'd12;
            5'd13: w_fwd = 5'd22;
            5'd14: w_fwd = 5'd7;
            5'd15: w_fwd = 5'd8;
            5'd16: w_fwd = 5'd18;
            5'd17: w_fwd = 5'd3;
            5'd18: w_fwd = 5'd13;
            5'd19: w_fwd = 5'd23;
            5'd20: w_fwd = 5'd24;
            5'd21: w_fwd = 5'd9;
            5'd22: w_fwd = 5'd19;
            5'd23: w_fwd = 5'd4;
            5'd24: w_fwd = 5'd14;
            default: w_fwd = 5'd0;
        endcase
    end

    // dst including this cycle's bit, so end-of-pass copies see the full line.
    always_comb begin
        w_dst_upd        = r_dst;
        w_dst_upd[r_cnt] = r_src[w_fwd];
    end

    assign w_last_bit = (r_cnt == c_last_bit);
    assign w_last_rnd = (r_rnd == c_last_rnd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_RUN;
            S_RUN:   if (w_last_bit && w_last_rnd) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_cnt      <= '0;
            r_rnd      <= '0;
            r_out_line <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_src <= in_line;
                        r_dst <= '0;
                        r_cnt <= '0;
                        r_rnd <= '0;
                    end
                end
                S_RUN: begin
                    r_dst <= w_dst_upd;
                    if (w_last_bit) begin
                        r_cnt <= '0;
                        if (w_last_rnd) begin
                            r_out_line <= w_dst_upd;
                        end else begin
                            r_src <= w_dst_upd;
                            r_rnd <= r_rnd + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign out_line  = r_out_line;

endmodule
`default_nettype wire

// File: tb/tb_unswap_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_unswap_decoder
// Purpose  : Self-checking bench for unswap_decoder at ROUNDS=1 and ROUNDS=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unswap_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] in_line   [2];
    logic        in_valid  [2];
    logic        out_ready [2];
    logic        in_ready  [2];
    logic [24:0] out_line  [2];
    logic        out_valid [2];
    logic        busy      [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    unswap_decoder #(.ROUNDS(1), .RW(4)) dut_r1 (
        .clk(clk), .rst(rst),
        .in_line(in_line[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_line(out_line[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0])
    );

    unswap_decoder #(.ROUNDS(3), .RW(4)) dut_r3 (
        .clk(clk), .rst(rst),
        .in_line(in_line[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_line(out_line[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1])
    );

    function automatic int rounds_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    // Matrix-coordinate form of the swap permutation.
    function automatic int fwd_m(input int i);
        int x, y, nx, ny;
        x  = (i % 5 + 3) % 5;
        y  = (i / 5 + 3) % 5;
        nx = (y + 2) % 5;
        ny = ((2 * x + 3 * y) % 5 + 2) % 5;
        return 5 * ny + nx;
    endfunction

    function automatic logic [24:0] encode_m(input logic [24:0] line, input int rounds);
        logic [24:0] src, dst;
        src = line;
        dst = '0;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 25; i++) dst[fwd_m(i)] = src[i];
            src = dst;
        end
        return src;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int s, input bit garbage, output int lat);
        lat = 0;
        while (out_valid[s] !== 1'b1 && lat < 400) begin
            if (garbage) begin
                in_valid[s] = 1'($urandom_range(0, 1));
                in_line[s]  = 25'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid[s] = 1'b0;
    endtask

    task automatic do_line(input int s, input logic [24:0] line, input logic [24:0] exp,
                           input bit garbage, input string name);
        int lat;
        out_ready[s] = 1'b1;
        in_line[s]   = line;
        in_valid[s]  = 1'b1;
        @(negedge clk);
        in_valid[s] = 1'b0;
        check({name, "_busy"}, 32'(busy[s]), 32'd1);
        wait_done(s, garbage, lat);
        check({name, "_latency"}, 32'(lat), 32'(25 * rounds_of(s)));
        check({name, "_line"}, 32'(out_line[s]), 32'(exp));
        @(negedge clk);
        check({name, "_idle"}, 32'({out_valid[s], in_ready[s]}), 32'b01);
    endtask

    typedef struct {
        int          s;
        logic [24:0] line;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] orig, l2;
        int lat;

        vecs[0] = '{0, 25'h0000400, 25'h0000001};
        vecs[1] = '{0, 25'h0100000, 25'h0000002};
        vecs[2] = '{0, 25'h0001000, 25'h0001000};
        vecs[3] = '{0, 25'h0004000, 25'h1000000};
        vecs[4] = '{0, 25'h0000000, 25'h0000000};
        vecs[5] = '{0, 25'h1FFFFFF, 25'h1FFFFFF};
        vecs[6] = '{1, 25'h0000000, 25'h0000000};
        vecs[7] = '{1, 25'h1FFFFFF, 25'h1FFFFFF};

        for (int s = 0; s < 2; s++) begin
            in_line[s]   = '0;
            in_valid[s]  = 1'b0;
            out_ready[s] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_out_valid", 32'(out_valid[s]), 32'd0);
            check("reset_in_ready", 32'(in_ready[s]), 32'd1);
            check("reset_busy", 32'(busy[s]), 32'd0);
            check("reset_out_line", 32'(out_line[s]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            do_line(vecs[i].s, vecs[i].line, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));

        // Round trip through the encoder model; every fourth line also sees garbage input during RUN.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 100; n++) begin
                orig = 25'($urandom);
                do_line(s, encode_m(orig, rounds_of(s)), orig, (n % 4) == 0, $sformatf("rt_r%0d_%0d", rounds_of(s), n));
            end
        end

        // Backpressure in DONE, then a line waiting on in_valid across the handshake.
        orig = 25'($urandom);
        out_ready[1] = 1'b0;
        in_line[1]   = encode_m(orig, 3);
        in_valid[1]  = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        wait_done(1, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd75);
        for (int k = 0; k < 40; k++) begin
            in_valid[1] = 1'b1;
            in_line[1]  = 25'($urandom);
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready[1]), 32'd0);
            check("bp_out_valid", 32'(out_valid[1]), 32'd1);
            check("bp_out_line", 32'(out_line[1]), 32'(orig));
        end
        l2 = 25'($urandom);
        in_line[1]   = encode_m(l2, 3);
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_handshake_state", 32'({out_valid[1], in_ready[1], busy[1]}), 32'b010);
        check("bp_handshake_line", 32'(out_line[1]), 32'(orig));
        @(negedge clk);
        in_valid[1] = 1'b0;
        check("bp_accept_state", 32'({in_ready[1], busy[1]}), 32'b01);
        wait_done(1, 1'b0, lat);
        check("bp_next_latency", 32'(lat), 32'd75);
        check("bp_next_line", 32'(out_line[1]), 32'(l2));
        @(negedge clk);

        // Reset during RUN discards the line.
        in_line[0]  = 25'($urandom);
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_out_line", 32'(out_line[0]), 32'd0);
        check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        orig = 25'($urandom);
        do_line(0, encode_m(orig, 1), orig, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unswap_decoder.md
Name: unswap_decoder

Overview:
- Inverse of the matrix encoder's 5x5 bit-permutation ("swap") stage.
- Accepts one 25-bit encoded line over a valid/ready handshake and rebuilds the original line bit-serially, one bit per clock.
- Repeats the inverse permutation ROUNDS times, then holds the decoded line until the consumer accepts it.
- Sits between the file-read path and the write-to-file path in the decode datapath.

Parameters:
- ROUNDS, 1, number of inverse-permutation passes applied per line (1..15); must equal the encoder's pass count.
- RW, 4, width of the internal round counter; must satisfy 2^RW > ROUNDS.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_line  input  25  encoded line; bit i is matrix cell x=i%5, y=i/5.
- in_valid  input  1  in_line is valid.
- in_ready  output  1  block can accept a line; high only in IDLE.
- out_line  output  25  decoded line, registered.
- out_valid  output  1  out_line holds a complete decoded line.
- out_ready  input  1  consumer accepts out_line.
- busy  output  1  high in RUN.

Behaviour:
- Permutation fwd(i), for i in 0..24, matches the encoder:
  - x=(i%5+3)%5, y=(i/5+3)%5
  - nx=(y+2)%5, ny=((2x+3y)%5+2)%5
  - fwd(i)=5*ny+nx
- One decode pass computes dst[i]=src[fwd(i)].
- Spot values: fwd(0)=10, fwd(1)=20, fwd(12)=12, fwd(24)=14.
- fwd is combinational from the 5-bit bit counter (small mod-5 logic or a 25-entry constant ROM). No per-bit index arithmetic beyond 5 bits.
- FSM states are IDLE, RUN, DONE.
- Reset, applied on any clock edge with rst=1 and overriding everything:
  - state goes to IDLE; out_line, src, dst, bit counter and round counter go to 0.
  - out_valid=0, busy=0, in_ready=1 in the cycle after reset.
  - Reset mid-RUN or mid-DONE discards the line; no partial output is produced.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: src<=in_line, dst<=0, cnt<=0, rnd<=0, go to RUN.
  - With in_valid=0, stay in IDLE.
- RUN (in_ready=0, busy=1), each edge:
  - dst[cnt]<=src[fwd(cnt)] and cnt<=cnt+1.
  - At cnt==24 with rnd<ROUNDS-1: src<=dst including the bit written this cycle, cnt<=0, rnd<=rnd+1.
  - At cnt==24 with rnd==ROUNDS-1: out_line<=final dst, go to DONE.
  - cnt never exceeds 24.
  - in_valid is ignored and no input is sampled.
- DONE (out_valid=1, in_ready=0):
  - out_line stays stable until accepted.
  - On out_ready=1 at an edge: go to IDLE. out_valid falls and out_line keeps its value.
  - A new line cannot be accepted in the same cycle as the DONE handshake; the earliest next accept is the edge after.
- Latency:
  - Accept edge at T.
  - out_valid is high after edge T+25*ROUNDS.
  - Throughput is one line per 25*ROUNDS+2 cycles with out_ready tied high.
- out_ready has no effect outside DONE.

Test Plan:
- Reset, then in_line=25'h0000400 (bit 10), in_valid pulsed one cycle, ROUNDS=1, out_ready=1:
  - out_valid rises exactly 25 cycles after accept, with out_line=25'h0000001.
  - Separately, bit 20 decodes to bit 1, bit 12 to bit 12, and bit 14 to bit 24.
- Round-trip: 200 random 25-bit lines passed through a behavioural encoder model (ROUNDS=1 and ROUNDS=3), then fed to the block:
  - out_line equals the original line every time; out_valid stays low until 25*ROUNDS cycles after each accept.
- Backpressure: hold out_ready=0 for 40 cycles in DONE while driving new in_line values with in_valid=1:
  - in_ready=0 throughout; out_line and out_valid stay stable.
  - The new line is accepted only on the edge after the out_ready handshake.
- Reset mid-operation: assert rst at cycle 12 of RUN:
  - Next cycle shows out_valid=0, out_line=0, in_ready=1, busy=0.
  - The following accepted line decodes correctly with full latency.
- Ignored input: toggle in_valid with garbage in_line during RUN:
  - Decoded result is unaffected.
- Edge patterns: all-zeros and all-ones (25'h1FFFFFF):
  - Each decodes to itself.
